// File: rtl/i8255_pkg.sv
// Shared constants for the i8255 mode-0 PPI: register addresses,
// control-word bit positions and the control register reset value.
package i8255_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW_W   = 7;

  localparam logic [ADDR_W-1:0] ADDR_PA   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_PB   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_PC   = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'b11;

  // Control-word bits; a 1 selects input for that port (or port half).
  localparam int unsigned CW_A_IN  = 4;
  localparam int unsigned CW_CH_IN = 3;
  localparam int unsigned CW_B_IN  = 1;
  localparam int unsigned CW_CL_IN = 0;

  // All ports configured as inputs.
  localparam logic [CW_W-1:0] CTRL_RESET = 7'b0011011;

endpackage

// File: rtl/i8255_ctrl_decode.sv
// Direction decode from the stored control word.
// Ports:
//   control_reg  in  7  stored control word (mode bits ignored)
//   ddra, ddrb   out 1  whole-port drive enables for A and B
//   ddrc         out 8  per-bit drive enables for port C
module i8255_ctrl_decode
  import i8255_pkg::*;
(
  input  logic [6:0] control_reg,
  output logic       ddra,
  output logic       ddrb,
  output logic [7:0] ddrc
);

  // Mode-select bits are stored for readback only; behaviour is always mode 0.
  logic unused_mode_bits;
  assign unused_mode_bits = ^{control_reg[6:5], control_reg[2]};

  assign ddra      = ~control_reg[CW_A_IN];
  assign ddrb      = ~control_reg[CW_B_IN];
  assign ddrc[7:4] = {4{~control_reg[CW_CH_IN]}};
  assign ddrc[3:0] = {4{~control_reg[CW_CL_IN]}};

endmodule

// File: rtl/i8255_ppi.sv
// Intel 8255 PPI, mode 0 only, with control-word mode set and port C
// bit set/reset. Pads are split into in/out/direction signals.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   cs, rd, wr, a, din  CPU bus slave interface
//   dout                combinational read data (0 unless reading)
//   ain, bin, cin       port pin inputs
//   aout, bout, cout    port output latches
//   ddra, ddrb, ddrc    drive enables (1 = drive)
module i8255_ppi
  import i8255_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] ain,
  input  logic [7:0] bin,
  input  logic [7:0] cin,
  output logic [7:0] aout,
  output logic [7:0] bout,
  output logic [7:0] cout,
  output logic       ddra,
  output logic       ddrb,
  output logic [7:0] ddrc
);

  logic [6:0] control_reg;
  logic       we;
  logic       bit_set_reset;

  assign we            = cs & wr;
  assign bit_set_reset = we & (a == ADDR_CTRL) & ~din[7];

  // Register file; latches update regardless of port direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg <= CTRL_RESET;
      aout        <= '0;
      bout        <= '0;
      cout        <= '0;
    end else if (we) begin
      case (a)
        ADDR_PA: aout <= din;
        ADDR_PB: bout <= din;
        ADDR_PC: cout <= din;
        default: begin
          if (din[7]) begin
            control_reg <= din[6:0];
            aout        <= '0;
            bout        <= '0;
            cout        <= '0;
          end else if (bit_set_reset) begin
            cout[din[3:1]] <= din[0];
          end
        end
      endcase
    end
  end

  i8255_ctrl_decode u_decode (
    .control_reg (control_reg),
    .ddra        (ddra),
    .ddrb        (ddrb),
    .ddrc        (ddrc)
  );

  // Read mux: driven ports return their latch, input ports return the pins.
  always_comb begin
    dout = '0;
    if (cs & rd & ~wr) begin
      case (a)
        ADDR_PA: dout = ddra ? aout : ain;
        ADDR_PB: dout = ddrb ? bout : bin;
        ADDR_PC: dout = (ddrc & cout) | (~ddrc & cin);
        default: dout = {1'b1, control_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_i8255_ppi.sv
module tb_i8255_ppi;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, rd, wr;
  logic [1:0] a;
  logic [7:0] din, dout, ain, bin, cin, aout, bout, cout, ddrc;
  logic       ddra, ddrb;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [6:0] m_ctrl;
  logic [7:0] m_a, m_b, m_c;

  i8255_ppi dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a(a),
    .din(din), .dout(dout), .ain(ain), .bin(bin), .cin(cin),
    .aout(aout), .bout(bout), .cout(cout),
    .ddra(ddra), .ddrb(ddrb), .ddrc(ddrc)
  );

  always #5 clk = ~clk;

  // Port A is an output when its "input" control bit (4) is clear, etc.
  function automatic logic m_ddra();
    return (m_ctrl[4] == 1'b0);
  endfunction
  function automatic logic m_ddrb();
    return (m_ctrl[1] == 1'b0);
  endfunction
  function automatic logic [7:0] m_ddrc();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i >= 4) ? (m_ctrl[3] == 1'b0) : (m_ctrl[0] == 1'b0);
    return r;
  endfunction

  function automatic logic [7:0] m_read(logic c, logic r, logic w, logic [1:0] ad,
                                        logic [7:0] pa, logic [7:0] pb, logic [7:0] pc);
    logic [7:0] v;
    logic [7:0] dc;
    if (!(c && r && !w)) return 8'h00;
    dc = m_ddrc();
    case (ad)
      2'd0: v = m_ddra() ? m_a : pa;
      2'd1: v = m_ddrb() ? m_b : pb;
      2'd2: for (int i = 0; i < 8; i++) v[i] = dc[i] ? m_c[i] : pc[i];
      default: v = 8'h80 + {1'b0, m_ctrl};
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [1:0] ad, input logic [7:0] d);
    case (ad)
      2'd0: m_a = d;
      2'd1: m_b = d;
      2'd2: m_c = d;
      default: begin
        if (d[7]) begin
          m_ctrl = d[6:0];
          m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
        end else begin
          m_c[d[3:1]] = d[0];
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_ctrl = 7'h1B; m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
  endtask

  // One write cycle; returns with strobes low, 1 time unit after the edge.
  task automatic do_write(input logic [1:0] ad, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; a = ad; din = d;
    @(posedge clk);
    model_write(ad, d);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    do_write(2'd0, 8'h55);
    do_write(2'd3, 8'h80);
    do_write(2'd2, 8'hAA);
    // Reset asserted together with a write: reset wins.
    reset = 1'b1; cs = 1'b1; wr = 1'b1; a = 2'd1; din = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0; cs = 1'b0; wr = 1'b0;
    model_reset();
    n_cmp++; if (dut.control_reg !== 7'h1B) begin n_fail++; $display("FAIL reset_ctrl got %h exp 1b", dut.control_reg); end
    n_cmp++; if ({ddra, ddrb, ddrc} !== 10'h000) begin n_fail++; $display("FAIL reset_ddr got %b %b %h exp 0 0 00", ddra, ddrb, ddrc); end
    n_cmp++; if ({aout, bout, cout} !== 24'h0) begin n_fail++; $display("FAIL reset_out got %h %h %h exp 00 00 00", aout, bout, cout); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
  endtask

  task automatic test_mode_sweep();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] w;
      logic [3:0] iv;
      iv = 4'(i);
      w = 8'h80 | {3'b000, iv[3], iv[2], 1'b0, iv[1], iv[0]};
      do_write(2'd3, w);
      n_cmp++;
      if (ddra !== m_ddra() || ddrb !== m_ddrb() || ddrc !== m_ddrc()) begin
        n_fail++; $display("FAIL mode_sweep cw=%h got %b %b %h exp %b %b %h", w, ddra, ddrb, ddrc, m_ddra(), m_ddrb(), m_ddrc());
      end
      if (w == 8'h80) begin n_cmp++; if ({ddra, ddrb, ddrc} !== {2'b11, 8'hFF}) begin n_fail++; $display("FAIL cw80 got %b %b %h exp 1 1 ff", ddra, ddrb, ddrc); end end
      if (w == 8'h81) begin n_cmp++; if ({ddra, ddrb, ddrc} !== {2'b11, 8'hF0}) begin n_fail++; $display("FAIL cw81 got %b %b %h exp 1 1 f0", ddra, ddrb, ddrc); end end
      if (w == 8'h88) begin n_cmp++; if ({ddra, ddrb, ddrc} !== {2'b11, 8'h0F}) begin n_fail++; $display("FAIL cw88 got %b %b %h exp 1 1 0f", ddra, ddrb, ddrc); end end
      if (w == 8'h9B) begin n_cmp++; if ({ddra, ddrb, ddrc} !== {2'b00, 8'h00}) begin n_fail++; $display("FAIL cw9b got %b %b %h exp 0 0 00", ddra, ddrb, ddrc); end end
    end
  endtask

  task automatic test_data_and_bsr();
    do_write(2'd3, 8'h80);
    do_write(2'd0, 8'hA5);
    do_write(2'd1, 8'h5A);
    n_cmp++; if (dut.bit_set_reset !== 1'b0) begin n_fail++; $display("FAIL bsr_idle got %b exp 0", dut.bit_set_reset); end
    do_write(2'd2, 8'h96);
    n_cmp++; if ({aout, bout, cout} !== 24'hA55A96) begin n_fail++; $display("FAIL data_wr got %h %h %h exp a5 5a 96", aout, bout, cout); end
    // BSR: clear bit 7, then set bit 3.
    cs = 1'b1; wr = 1'b1; a = 2'd3; din = 8'h0E; #1;
    n_cmp++; if (dut.bit_set_reset !== 1'b1) begin n_fail++; $display("FAIL bsr_pulse1 got %b exp 1", dut.bit_set_reset); end
    @(posedge clk); model_write(2'd3, 8'h0E); #1; cs = 1'b0; wr = 1'b0; #1;
    n_cmp++; if (cout !== 8'h16) begin n_fail++; $display("FAIL bsr_clr got %h exp 16", cout); end
    n_cmp++; if (dut.bit_set_reset !== 1'b0) begin n_fail++; $display("FAIL bsr_off got %b exp 0", dut.bit_set_reset); end
    do_write(2'd3, 8'h07);
    n_cmp++; if (cout !== 8'h1E) begin n_fail++; $display("FAIL bsr_set got %h exp 1e", cout); end
    n_cmp++; if (dut.control_reg !== 7'h00) begin n_fail++; $display("FAIL bsr_ctrl got %h exp 00", dut.control_reg); end
    // BSR with din[6:4] set must still not touch control.
    do_write(2'd3, 8'h71);
    n_cmp++; if (cout !== m_c || dut.control_reg !== 7'h00) begin n_fail++; $display("FAIL bsr_hi got %h %h exp %h 00", cout, dut.control_reg, m_c); end
    do_write(2'd3, 8'h80);
    n_cmp++; if ({aout, bout, cout} !== 24'h0) begin n_fail++; $display("FAIL mode_clear got %h %h %h exp 0 0 0", aout, bout, cout); end
  endtask

  task automatic test_reads();
    do_write(2'd3, 8'h9B);
    ain = 8'h3C; cs = 1'b1; rd = 1'b1; a = 2'd0; #1;
    n_cmp++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL rd_pa_in got %h exp 3c", dout); end
    cs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rd_nocs got %h exp 00", dout); end
    rd = 1'b0;
    do_write(2'd3, 8'h80);
    do_write(2'd0, 8'h77);
    cs = 1'b1; rd = 1'b1; a = 2'd0; #1;
    n_cmp++; if (dout !== 8'h77) begin n_fail++; $display("FAIL rd_pa_out got %h exp 77", dout); end
    a = 2'd3; #1;
    n_cmp++; if (dout !== 8'h80) begin n_fail++; $display("FAIL rd_ctrl got %h exp 80", dout); end
    // rd and wr together: the write happens, the read returns 0.
    wr = 1'b1; a = 2'd1; din = 8'hC3; #1;
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rdwr_dout got %h exp 00", dout); end
    @(posedge clk); model_write(2'd1, 8'hC3); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    n_cmp++; if (bout !== 8'hC3) begin n_fail++; $display("FAIL rdwr_write got %h exp c3", bout); end
  endtask

  task automatic test_back_to_back();
    cs = 1'b1; wr = 1'b1; rd = 1'b0;
    a = 2'd0; din = 8'h11; @(posedge clk); model_write(a, din); #1;
    a = 2'd1; din = 8'h22; @(posedge clk); model_write(a, din); #1;
    a = 2'd2; din = 8'h33; @(posedge clk); model_write(a, din); #1;
    a = 2'd3; din = 8'h01; @(posedge clk); model_write(a, din); #1;
    // Held write applied repeatedly.
    a = 2'd0; din = 8'h44;
    repeat (3) begin @(posedge clk); model_write(a, din); end
    #1; cs = 1'b0; wr = 1'b0;
    n_cmp++; if ({aout, bout, cout} !== {m_a, m_b, m_c}) begin n_fail++; $display("FAIL b2b got %h %h %h exp %h %h %h", aout, bout, cout, m_a, m_b, m_c); end
    n_cmp++; if ({aout, bout, cout} !== 24'h442233) begin n_fail++; $display("FAIL b2b_abs got %h %h %h exp 44 22 33", aout, bout, cout); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] exp_rd;
      cs  = 1'($urandom_range(0, 3) != 0);
      rd  = 1'($urandom);
      wr  = 1'($urandom_range(0, 2) == 0);
      a   = 2'($urandom);
      din = 8'($urandom);
      if (a == 2'd3 && din[7] && $urandom_range(0, 3) != 0) din[7] = 1'b0;
      ain = 8'($urandom); bin = 8'($urandom); cin = 8'($urandom);
      #1;
      exp_rd = m_read(cs, rd, wr, a, ain, bin, cin);
      n_cmp++;
      if (dout !== exp_rd) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_rd n=%0d a=%0d got %h exp %h", n, a, dout, exp_rd);
      end
      @(posedge clk);
      if (cs && wr) model_write(a, din);
      #1;
      n_cmp++;
      if ({aout, bout, cout} !== {m_a, m_b, m_c} || dut.control_reg !== m_ctrl ||
          ddra !== m_ddra() || ddrb !== m_ddrb() || ddrc !== m_ddrc()) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_state n=%0d got %h %h %h %h exp %h %h %h %h", n, aout, bout, cout, dut.control_reg, m_a, m_b, m_c, m_ctrl);
      end
    end
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; a = 2'd0; din = 8'h00;
    ain = 8'h00; bin = 8'h00; cin = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    test_reset();
    test_mode_sweep();
    test_data_and_bsr();
    test_reads();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
